pc_sequencer: RTL

Multi-cycle PC sequencer for the npc core. It owns the PC register and fetches each instruction over a valid/ready instruction-fetch interface. It holds the instruction stable while execute runs, then applies the branch-condition unit's PC-adder selects to form and commit the next PC. Sits between the IFU memory port and the decode/execute/branch-condition datapath.

---
 rtl/npc_pkg.sv | 18 +
 rtl/pc_sequencer_if.sv | 21 ++
 rtl/pc_sequencer_next_pc_adder.sv | 27 ++
 rtl/pc_sequencer.sv | 106 ++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared definitions for the npc core: sequencer state encoding and fixed constants.
// The TRAP encoding is only present when PC_MISALIGN_TRAP_EN is defined.
package npc_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam int unsigned PC_STEP          = 4;

  typedef enum logic [1:0] {
    S_REQ      = 2'd0,
    S_WAIT_RSP = 2'd1,
    S_EXEC     = 2'd2
`ifdef PC_MISALIGN_TRAP_EN
    ,S_TRAP    = 2'd3
`endif
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-fetch valid/ready channel between the PC sequencer (master) and IFU memory (slave).
interface pc_sequencer_if #(
  parameter int XLEN = 32
);
  logic            ifu_req_valid;
  logic            ifu_req_ready;
  logic [XLEN-1:0] ifu_req_addr;
  logic            ifu_rsp_valid;
  logic            ifu_rsp_ready;
  logic [31:0]     ifu_rsp_data;

  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data
  );

  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data
  );
endinterface

// File: rtl/pc_sequencer_next_pc_adder.sv
// Combinational next-PC former: operand selects, modulo-2^XLEN add and JALR bit-0 clear.
module next_pc_adder
  import npc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic            pc_a_src,
  input  logic            pc_b_src,
  input  logic            is_jalr,
  output logic [XLEN-1:0] next_pc
);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;

  always_comb begin
    op_a    = pc_a_src ? imm : XLEN'(PC_STEP);
    op_b    = pc_b_src ? rs1_val : pc;
    // Carry out is intentionally dropped so targets wrap around the address space.
    next_pc = op_a + op_b;
    if (is_jalr) next_pc[0] = 1'b0;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: fetch over the IFU channel, hold inst through execute, commit next PC.
// Optional misaligned-target trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_sequencer
  import npc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_sequencer_if.master  ifu,
  output logic [31:0]     inst,
  output logic            inst_valid,
  input  logic            exe_done,
  input  logic            pc_a_src,
  input  logic            pc_b_src,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic            is_jalr,
  output logic [XLEN-1:0] pc,
`ifdef PC_MISALIGN_TRAP_EN
  output logic            misalign_trap,
`endif
  output logic            commit
);

  seq_state_e      state;
  seq_state_e      state_nxt;
  logic [XLEN-1:0] next_pc;
  logic            do_commit;
  logic            do_latch;

  next_pc_adder #(.XLEN(XLEN)) u_adder (
    .pc      (pc),
    .imm     (imm),
    .rs1_val (rs1_val),
    .pc_a_src(pc_a_src),
    .pc_b_src(pc_b_src),
    .is_jalr (is_jalr),
    .next_pc (next_pc)
  );

  assign ifu.ifu_req_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      inst   <= INST_NOP;
      commit <= 1'b0;
    end else begin
      state  <= state_nxt;
      commit <= do_commit;
      if (do_commit) pc <= next_pc;
      if (do_latch) inst <= ifu.ifu_rsp_data;
    end
  end

  always_comb begin
    state_nxt         = state;
    do_commit         = 1'b0;
    do_latch          = 1'b0;
    ifu.ifu_req_valid = 1'b0;
    ifu.ifu_rsp_ready = 1'b0;
    inst_valid        = 1'b0;
    case (state)
      S_REQ: begin
        ifu.ifu_req_valid = 1'b1;
        if (ifu.ifu_req_ready) state_nxt = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        ifu.ifu_rsp_ready = 1'b1;
        if (ifu.ifu_rsp_valid) begin
          do_latch  = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        inst_valid = 1'b1;
        if (exe_done) begin
`ifdef PC_MISALIGN_TRAP_EN
          if (next_pc[1:0] != 2'b00) begin
            state_nxt = S_TRAP;
          end else begin
            do_commit = 1'b1;
            state_nxt = S_REQ;
          end
`else
          do_commit = 1'b1;
          state_nxt = S_REQ;
`endif
        end
      end
`ifdef PC_MISALIGN_TRAP_EN
      // Sticky: only rst_n leaves the trap state.
      S_TRAP: state_nxt = S_TRAP;
`endif
      default: state_nxt = S_REQ;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign misalign_trap = (state == S_TRAP);
`endif

endmodule
